// File: rtl/fmul_pkg.sv
// Shared types and constants for the FP multiply issue arbiter.
// Requester ids, result-owner tag layout and default pipeline latency.
package fmul_pkg;

    localparam int FMUL_ID_W = 1;
    localparam logic [FMUL_ID_W-1:0] FMUL_ID0 = 1'b0;
    localparam logic [FMUL_ID_W-1:0] FMUL_ID1 = 1'b1;
    localparam int FMUL_LATENCY_DEFAULT = 4;

    typedef struct packed {
        logic                 valid;
        logic [FMUL_ID_W-1:0] id;
    } fmul_tag_t;

endpackage

// File: rtl/fmul_tag_pipe.sv
// Owner-tag delay line, DEPTH stages, asynchronous active-low clear.
// The tag leaves the last stage in the cycle its result leaves the pipeline.
module fmul_tag_pipe
    import fmul_pkg::*;
#(
    parameter int DEPTH = FMUL_LATENCY_DEFAULT
) (
    input  logic      clk,
    input  logic      rst_n,
    input  fmul_tag_t tag_i,
    output fmul_tag_t tag_o
);

    fmul_tag_t [DEPTH-1:0] stage_q;
    fmul_tag_t [DEPTH-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = tag_i;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/fmul_issue_arbiter.sv
// Two-requester issue arbiter and result router for the shared FP multiplier.
// Define FMUL_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module fmul_issue_arbiter
    import fmul_pkg::*;
#(
    parameter int LATENCY = FMUL_LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic        req1,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        do_fmul,
    output logic [31:0] fa,
    output logic [31:0] fb,
    input  logic        res_valid,
    input  logic [31:0] res,
    output logic        done0,
    output logic        done1,
    output logic [31:0] r,
    output logic        err
);

    logic                 gnt0_q, gnt0_d;
    logic                 gnt1_q, gnt1_d;
    logic                 issue_q, issue_d;
    logic [FMUL_ID_W-1:0] id_q, id_d;
    logic [31:0]          fa_q, fa_d;
    logic [31:0]          fb_q, fb_d;
    logic                 done0_q, done0_d;
    logic                 done1_q, done1_d;
    logic [31:0]          r_q, r_d;
    logic                 err_q, err_d;

    logic      elig0, elig1;
    logic      win0, win1;
    logic      hit;
    fmul_tag_t tag_in, tag_out;

    // A requester granted this cycle is masked while it drops its request.
    assign elig0 = req0 & ~gnt0_q;
    assign elig1 = req1 & ~gnt1_q;

`ifdef FMUL_ARB_FIXED_PRIO_EN
    assign win0 = elig0;
`else
    logic [FMUL_ID_W-1:0] ptr_q, ptr_d;

    assign win0 = elig0 & (~elig1 | (ptr_q == FMUL_ID0));

    always_comb begin
        ptr_d = ptr_q;
        if (elig0 && elig1) begin
            ptr_d = win0 ? FMUL_ID1 : FMUL_ID0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= FMUL_ID0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign win1 = elig1 & ~win0;

    always_comb begin
        gnt0_d  = win0;
        gnt1_d  = win1;
        issue_d = win0 | win1;
        id_d    = win1 ? FMUL_ID1 : FMUL_ID0;
        fa_d    = fa_q;
        fb_d    = fb_q;
        if (win0) begin
            fa_d = a0;
            fb_d = b0;
        end else if (win1) begin
            fa_d = a1;
            fb_d = b1;
        end
    end

    assign tag_in.valid = issue_q;
    assign tag_in.id    = id_q;

    fmul_tag_pipe #(
        .DEPTH (LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    // A valid/tag disagreement is never routed; it only raises err.
    assign hit = res_valid & tag_out.valid;

    always_comb begin
        done0_d = hit & (tag_out.id == FMUL_ID0);
        done1_d = hit & (tag_out.id == FMUL_ID1);
        r_d     = hit ? res : r_q;
        err_d   = err_q | (res_valid ^ tag_out.valid);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            issue_q <= 1'b0;
            id_q    <= FMUL_ID0;
            fa_q    <= '0;
            fb_q    <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            r_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            issue_q <= issue_d;
            id_q    <= id_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            r_q     <= r_d;
            err_q   <= err_d;
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign do_fmul = issue_q;
    assign fa      = fa_q;
    assign fb      = fb_q;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign r       = r_q;
    assign err     = err_q;

endmodule

// File: tb/tb_fmul_issue_arbiter.sv
// Directed scoreboard bench for fmul_issue_arbiter with a model pipeline.
// Honors FMUL_ARB_FIXED_PRIO_EN when choosing arbitration expectations.
module tb_fmul_issue_arbiter;

    localparam int L = 4;
    localparam int DROP = 0;
    localparam int HOLD = 1;
    localparam int REPL = 2;

    typedef struct {
        logic        id;
        logic [31:0] r;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_rst_n = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        gnt0, gnt1, do_fmul, done0, done1, err;
    logic [31:0] fa, fb, r;
    logic        res_valid;
    logic [31:0] res;
    logic        inj = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_done = -1;
    int n_done0 = 0;
    int n_done1 = 0;
    int m0 = DROP;
    int m1 = DROP;
    int c0;
    exp_t sbq[$];
    logic [1:0] gnt_log[$];
    logic dof_log[$];

    always #5 clk = ~clk;

    fmul_issue_arbiter #(.LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .do_fmul(do_fmul), .fa(fa), .fb(fb),
        .res_valid(res_valid), .res(res),
        .done0(done0), .done1(done1),
        .r(r), .err(err)
    );

    function automatic logic [31:0] pipe_fn(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3FC00000 && b == 32'h40000000)
            return 32'h40400000;
        return a ^ {b[15:0], b[31:16]};
    endfunction

    logic [L-1:0] pv;
    logic [31:0]  pd [L];

    always_ff @(posedge clk or negedge pipe_rst_n) begin
        if (!pipe_rst_n) begin
            pv <= '0;
            for (int i = 0; i < L; i++) pd[i] <= '0;
        end else begin
            pv <= {pv[L-2:0], do_fmul};
            pd[0] <= pipe_fn(fa, fb);
            for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
        end
    end

    assign res_valid = pv[L-1] | inj;
    assign res = pd[L-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        gnt_log.push_back({gnt1, gnt0});
        dof_log.push_back(do_fmul);
        check("done_excl", 32'(done0 & done1), 32'd0);
        if (done0) n_done0++;
        if (done1) n_done1++;
        if (done0 || done1) begin
            last_done = cyc;
            if (sbq.size() == 0) begin
                check("done_unexp", 32'({done1, done0}), 32'd0);
            end else begin
                e = sbq.pop_front();
                check("done_id", 32'(done1), 32'(e.id));
                check("done_r", r, e.r);
            end
        end
        if (gnt0) begin
            check("iss_fa0", fa, a0);
            sbq.push_back('{1'b0, pipe_fn(a0, b0)});
            if (m0 == DROP) req0 = 1'b0;
            else if (m0 == REPL) begin
                a0 = a0 + 32'h100;
                b0 = b0 ^ 32'h5;
            end
        end
        if (gnt1) begin
            check("iss_fa1", fa, a1);
            sbq.push_back('{1'b1, pipe_fn(a1, b1)});
            if (m1 == DROP) req1 = 1'b0;
            else if (m1 == REPL) begin
                a1 = a1 + 32'h200;
                b1 = b1 ^ 32'h9;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        pipe_rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        inj = 1'b0;
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        pipe_rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 20 && (req0 || req1); k++) cycle();
        check({tag, "_dropped"}, 32'({req1, req0}), 32'd0);
        repeat (L + 3) cycle();
        check({tag, "_sb_empty"}, 32'(sbq.size()), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"}, 32'({gnt1, gnt0}), 32'd0);
        check({tag, "_dof"}, 32'(do_fmul), 32'd0);
        check({tag, "_fa"}, fa, 32'd0);
        check({tag, "_fb"}, fb, 32'd0);
        check({tag, "_done"}, 32'({done1, done0}), 32'd0);
        check({tag, "_r"}, r, 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        rst = 1'b0;
        pipe_rst_n = 1'b0;
        #1;
        check_zero("rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        pipe_rst_n = 1'b1;

        // single issue from requester 0
        cycle();
        m0 = DROP;
        a0 = 32'h3FC00000;
        b0 = 32'h40000000;
        req0 = 1'b1;
        c0 = cyc;
        n_done1 = 0;
        cycle();
        check("t1_gnt0", 32'(gnt0), 32'd1);
        check("t1_dof", 32'(do_fmul), 32'd1);
        check("t1_fb", fb, 32'h40000000);
        cycle();
        check("t1_gnt0_pulse", 32'(gnt0), 32'd0);
        check("t1_dof_pulse", 32'(do_fmul), 32'd0);
        repeat (8) cycle();
        check("t1_latency", 32'(last_done), 32'(c0 + L + 2));
        check("t1_r", r, 32'h40400000);
        check("t1_no_done1", 32'(n_done1), 32'd0);
        check("t1_sb_empty", 32'(sbq.size()), 32'd0);

        // contention, both re-requesting immediately
        do_reset();
        m0 = REPL;
        m1 = REPL;
        a0 = 32'h11110000; b0 = 32'h0000AAAA;
        a1 = 32'h22220000; b1 = 32'h0000BBBB;
        req0 = 1'b1;
        req1 = 1'b1;
        gnt_log.delete();
        dof_log.delete();
        repeat (8) cycle();
        for (int i = 0; i < 8; i++) begin
            check("cont_gnt", 32'(gnt_log[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
            check("cont_dof", 32'(dof_log[i]), 32'd1);
        end
        m0 = DROP;
        m1 = DROP;
        drain("cont");

        // both raised together from idle: pointer now favours requester 1
        gnt_log.delete();
        a0 = 32'h33330000; b0 = 32'h00001234;
        a1 = 32'h44440000; b1 = 32'h00005678;
        req0 = 1'b1;
        req1 = 1'b1;
        cycle();
        cycle();
`ifdef FMUL_ARB_FIXED_PRIO_EN
        check("prio_first", 32'(gnt_log[0]), 32'd1);
        check("prio_second", 32'(gnt_log[1]), 32'd2);
`else
        check("rr_first", 32'(gnt_log[0]), 32'd2);
        check("rr_second", 32'(gnt_log[1]), 32'd1);
`endif
        drain("ptr");

        // grant mask: requester 0 holds its request
        gnt_log.delete();
        m0 = HOLD;
        a0 = 32'h55550000; b0 = 32'h00000F0F;
        req0 = 1'b1;
        repeat (8) cycle();
        for (int i = 0; i < 8; i++) begin
            check("mask_gnt", 32'(gnt_log[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        m0 = DROP;
        drain("mask");

        // unowned result strobe
        check("err_pre", 32'(err), 32'd0);
        n_done0 = 0;
        n_done1 = 0;
        inj = 1'b1;
        cycle();
        inj = 1'b0;
        check("err_set", 32'(err), 32'd1);
        repeat (3) cycle();
        check("err_sticky", 32'(err), 32'd1);
        check("err_no_done", 32'(n_done0 + n_done1), 32'd0);
        do_reset();
        check("err_clr", 32'(err), 32'd0);

        // reset mid-operation with pipeline reset too
        cycle();
        m0 = DROP;
        a0 = 32'h66660000; b0 = 32'h00003C3C;
        req0 = 1'b1;
        cycle();
        check("mid_gnt0", 32'(gnt0), 32'd1);
        cycle();
        cycle();
        rst = 1'b0;
        pipe_rst_n = 1'b0;
        sbq.delete();
        #1;
        check_zero("mid");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        pipe_rst_n = 1'b1;
        n_done0 = 0;
        n_done1 = 0;
        repeat (L + 3) cycle();
        check("mid_no_done", 32'(n_done0 + n_done1), 32'd0);
        check("mid_no_err", 32'(err), 32'd0);

        // reset of this block only: in-flight result arrives unowned
        req0 = 1'b1;
        cycle();
        check("orph_gnt0", 32'(gnt0), 32'd1);
        cycle();
        cycle();
        rst = 1'b0;
        sbq.delete();
        #1;
        check("orph_rst_dof", 32'(do_fmul), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        n_done0 = 0;
        n_done1 = 0;
        repeat (L + 2) cycle();
        check("orph_err", 32'(err), 32'd1);
        check("orph_no_done", 32'(n_done0 + n_done1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fmul_issue_arbiter.md
# fmul_issue_arbiter

Two-requester issue arbiter and result router for the shared single-precision multiply pipeline. It selects one pending request per cycle and drives the pipeline's `do_fmul`/operand inputs. It tracks each issued operation's owner through a tag shift register matched to the pipeline latency, and returns each result to its owner with a done pulse. It sits between the two consumer units and the multiply pipeline, and makes that pipeline the only shared FP multiply resource.

## Interface
Parameters:
- `LATENCY`, 4: cycles from `do_fmul` high to `res_valid` high at the pipeline output; legal range 1..16.

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted when 0)
- `req0` / `req1`  in  1  request from requester 0/1; held until the matching grant
- `a0`, `b0` / `a1`, `b1`  in  32  IEEE-754 operands; stable while the request is high
- `gnt0` / `gnt1`  out  1  one-cycle grant pulse, coincident with the issue cycle
- `do_fmul`  out  1  issue strobe to the pipeline
- `fa`, `fb`  out  32  operands to the pipeline; valid when `do_fmul`=1
- `res_valid`  in  1  result strobe from the pipeline
- `res`  in  32  pipeline result
- `done0` / `done1`  out  1  one-cycle result pulse to owner 0/1
- `r`  out  32  routed result; valid when `done0` or `done1` is 1
- `err`  out  1  sticky tag/valid mismatch flag

## Operation
- Reset values: all outputs 0; round-robin pointer = requester 0 has priority; tag register cleared; `err` = 0.
- Arbitration, each cycle:
  - Eligible requester i: `req_i`=1 and `gnt_i` not high this cycle. The mask prevents double issue while the requester is dropping its request.
  - One eligible requester: it wins.
  - Both eligible: the pointer holder wins, and the pointer moves to the other requester.
  - Neither eligible: nothing issues, and the pointer holds.
- Issue is registered. On the edge after the win, `do_fmul`=1, `fa`/`fb` take the winner's operands, and `gnt_i`=1.
- Requester rule: deassert or replace the request in the cycle `gnt_i` is seen.
  - One requester alone can issue at most every other cycle.
  - Alternating requesters can issue every cycle.
- Tag register:
  - `LATENCY`-deep shift of {valid, id}.
  - Stage 0 loads {`do_fmul`, winner id}.
  - The tag emerges aligned with `res_valid`.
- Routing: when `res_valid`=1 and the emerging tag is valid, the next edge gives `r` = `res` and a pulse on `done_id`. `r` holds its last value otherwise.
- Error detection: `err` sets when `res_valid` disagrees with the emerging tag valid (either direction). It clears only on reset. On a mismatch, no done pulse is issued.
- Reset mid-operation clears the tag register. Results already in flight in the pipeline are then unowned and set `err` if they arrive. The system resets the pipeline together with this block.

## Timing
- Arbitration to issue: request sampled at edge n; `do_fmul`/`gnt` high in cycle n+1.
- Issue to done: `do_fmul` in cycle t, `res_valid` in cycle t+`LATENCY`, `done`/`r` in cycle t+`LATENCY`+1.
- Request-to-done latency: `LATENCY`+2 cycles.
- Throughput: one issue per cycle, one done per cycle.
- `done0` and `done1` are never both high.
- Simultaneous `res_valid` and a new issue: independent, no interaction.

## Configuration
- `FMUL_ARB_FIXED_PRIO_EN`:
  - Defined: requester 0 always wins when both are eligible. The pointer logic is removed and requester 1 can starve.
  - Undefined (default): round-robin as above.

## Structure
- Package `fmul_pkg`:
  - `FMUL_ID_W` = 1
  - requester id constants `FMUL_ID0`/`FMUL_ID1`
  - `fmul_tag_t` {valid, id}
  - `FMUL_LATENCY_DEFAULT` = 4
- Sub-module `fmul_tag_pipe`: parameterised-depth shift register of `fmul_tag_t` with async active-low clear.

## Test plan
- Reset, then single issue:
  - Stimulus: `req0`=1, `a0`=0x3FC00000, `b0`=0x40000000; the model pipeline returns 0x40400000 after `LATENCY`=4.
  - Expect: `gnt0` one cycle; `done0` with `r`=0x40400000 exactly 6 cycles after `req0` was sampled; `done1` stays 0.
- Contention:
  - Stimulus: `req0` and `req1` both high from reset, with each requester re-requesting immediately.
  - Expect: grants alternate 0,1,0,1; `do_fmul` high every cycle; the dones return in the same order.
- Grant mask:
  - Stimulus: `req0` held high continuously.
  - Expect: `gnt0` on alternate cycles only; no two consecutive issues from requester 0.
- Fixed priority, with `FMUL_ARB_FIXED_PRIO_EN` defined:
  - Stimulus: both requests held high.
  - Expect: `gnt1` only in the cycles where requester 0 is masked.
- Error detection:
  - Stimulus: inject `res_valid`=1 with no prior issue.
  - Expect: `err`=1 on the next cycle and stays set; no `done` pulse; cleared only by `rst`=0.
- Reset mid-operation:
  - Stimulus: assert `rst` low 2 cycles after an issue.
  - Expect: all outputs 0 immediately (async); no `done` afterward even if the model pipeline is also reset.
